pu_input_scheduler: RTL and testbench

- Shares one input-activation memory read port among NUM_PU processing units that run bit-serial convolution in parallel.
- Launches a layer by pulsing start to every PU.
- Grants their level-held input requests round-robin, reads each PU's next pixel from its own channel region, and returns the value with a one-cycle ready pulse.
- Collects per-PU done and signals layer completion.

---
 rtl/bisc_sched_pkg.sv | 27 ++
 rtl/pu_input_scheduler_if.sv | 36 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/pu_input_scheduler.sv | 165 ++++++++++++++++
 tb/tb_pu_input_scheduler.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bisc_sched_pkg.sv
// Shared types and default sizes for the PU input scheduler.
// State encoding, default geometry and width helper.
package bisc_sched_pkg;

  localparam int DEF_NUM_PU       = 4;
  localparam int DEF_BIN_LEN      = 8;
  localparam int DEF_INPUT_HEIGHT = 8;
  localparam int DEF_INPUT_WIDTH  = 8;

  localparam int PIX_TOTAL = DEF_INPUT_HEIGHT * DEF_INPUT_WIDTH;
  localparam int PIX_LOG   = $clog2(PIX_TOTAL);
  localparam int PU_LOG    = (DEF_NUM_PU > 1) ? $clog2(DEF_NUM_PU) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ARB,
    S_READ,
    S_RESP,
    S_FINISH
  } state_e;

  function automatic int log2_min1(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pu_input_scheduler_if.sv
// PU-side and memory-side bus of the input scheduler.
// master: scheduler; slave: PUs + activation memory.
interface pu_input_scheduler_if
  import bisc_sched_pkg::*;
#(
  parameter int NUM_PU  = DEF_NUM_PU,
  parameter int BIN_LEN = DEF_BIN_LEN,
  parameter int ADDR_W  = PU_LOG + PIX_LOG
) ();

  logic                start;
  logic [NUM_PU-1:0]   pu_start;
  logic [NUM_PU-1:0]   pu_input_req;
  logic [BIN_LEN-1:0]  pu_input_val;
  logic [NUM_PU-1:0]   pu_input_ready;
  logic [NUM_PU-1:0]   pu_done;
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_rd_addr;
  logic [BIN_LEN-1:0]  mem_rd_data;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    input  start, pu_input_req, pu_done, mem_rd_data,
    output pu_start, pu_input_val, pu_input_ready,
    output mem_rd_en, mem_rd_addr, busy, done, err
  );

  modport slave (
    output start, pu_input_req, pu_done, mem_rd_data,
    input  pu_start, pu_input_val, pu_input_ready,
    input  mem_rd_en, mem_rd_addr, busy, done, err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter, search starts at last_grant+1.
// In: req, last_grant, enable. Out: one-hot grant, grant_idx, any_grant.
module rr_arbiter
  import bisc_sched_pkg::*;
#(
  parameter int NUM_PU = DEF_NUM_PU,
  localparam int W     = log2_min1(NUM_PU)
) (
  input  logic [NUM_PU-1:0] req,
  input  logic [W-1:0]      last_grant,
  input  logic              enable,
  output logic [NUM_PU-1:0] grant,
  output logic [W-1:0]      grant_idx,
  output logic              any_grant
);

  int k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    k         = 0;
    for (int i = 1; i <= NUM_PU; i++) begin
      k = (int'(last_grant) + i) % NUM_PU;
      if (enable && !any_grant && req[k]) begin
        grant[k]  = 1'b1;
        grant_idx = W'(k);
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pu_input_scheduler.sv
// Shares one activation-memory read port among NUM_PU bit-serial PUs.
// Ports: clock, reset_n (sync, active low), bus (master modport).
module pu_input_scheduler
  import bisc_sched_pkg::*;
#(
  parameter int NUM_PU       = DEF_NUM_PU,
  parameter int BIN_LEN      = DEF_BIN_LEN,
  parameter int INPUT_HEIGHT = DEF_INPUT_HEIGHT,
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH
) (
  input logic                  clock,
  input logic                  reset_n,
  pu_input_scheduler_if.master bus
);

  localparam int PU_W  = log2_min1(NUM_PU);
  localparam int PIX_W = $clog2(INPUT_HEIGHT * INPUT_WIDTH);
  localparam int CNT_W = PIX_W + 1;
  localparam logic [CNT_W-1:0] PIX_FULL =
    CNT_W'(INPUT_HEIGHT * INPUT_WIDTH);

  state_e                  state_q, state_d;
  logic [PU_W-1:0]         grant_q, grant_d;
  logic [NUM_PU-1:0]       grant_oh_q, grant_oh_d;
  logic [PU_W-1:0]         last_grant_q, last_grant_d;
  logic [CNT_W-1:0]        pix_cnt_q [NUM_PU];
  logic [CNT_W-1:0]        pix_cnt_d [NUM_PU];
  logic [NUM_PU-1:0]       done_mask_q, done_mask_d;
  logic                    err_q, err_d;
  logic                    rd_en_q, rd_en_d;
  logic [PU_W+PIX_W-1:0]   rd_addr_q, rd_addr_d;
  logic [NUM_PU-1:0]       ready_q, ready_d;
  logic [BIN_LEN-1:0]      val_q, val_d;

  logic [NUM_PU-1:0]       exhausted;
  logic [NUM_PU-1:0]       eligible;
  logic [NUM_PU-1:0]       overrun;
  logic                    arb_en;
  logic [NUM_PU-1:0]       arb_oh;
  logic [PU_W-1:0]         arb_idx;
  logic                    arb_any;

  always_comb begin
    exhausted = '0;
    for (int i = 0; i < NUM_PU; i++) begin
      exhausted[i] = (pix_cnt_q[i] == PIX_FULL);
    end
  end

  assign eligible = bus.pu_input_req & ~done_mask_q & ~exhausted;
  assign overrun  = bus.pu_input_req & ~done_mask_q & exhausted;

  rr_arbiter #(.NUM_PU(NUM_PU)) u_arb (
    .req        (eligible),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .grant      (arb_oh),
    .grant_idx  (arb_idx),
    .any_grant  (arb_any)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
    pix_cnt_d    = pix_cnt_q;
    done_mask_d  = done_mask_q;
    err_d        = err_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    ready_d      = '0;
    val_d        = val_q;
    arb_en       = 1'b0;

    if (state_q inside {S_START, S_ARB, S_READ, S_RESP}) begin
      done_mask_d = done_mask_q | bus.pu_done;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_START;
          done_mask_d = '0;
          err_d       = 1'b0;
          for (int i = 0; i < NUM_PU; i++) begin
            pix_cnt_d[i] = '0;
          end
        end
      end
      S_START: state_d = S_ARB;
      S_ARB: begin
        if (&done_mask_q) begin
          state_d = S_FINISH;
        end else begin
          arb_en = 1'b1;
          // exhausted requesters are flagged but never granted
          if (|overrun) err_d = 1'b1;
          if (arb_any) begin
            grant_d    = arb_idx;
            grant_oh_d = arb_oh;
            rd_en_d    = 1'b1;
            rd_addr_d  = {arb_idx, pix_cnt_q[arb_idx][PIX_W-1:0]};
            state_d    = S_READ;
          end
        end
      end
      S_READ: begin
        // ready lands in RESP, same cycle the memory data is valid
        ready_d = grant_oh_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        val_d              = bus.mem_rd_data;
        pix_cnt_d[grant_q] = pix_cnt_q[grant_q] + CNT_W'(1);
        last_grant_d       = grant_q;
        state_d            = S_ARB;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= PU_W'(NUM_PU - 1);
      done_mask_q  <= '0;
      err_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      ready_q      <= '0;
      val_q        <= '0;
      for (int i = 0; i < NUM_PU; i++) begin
        pix_cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      done_mask_q  <= done_mask_d;
      err_q        <= err_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      ready_q      <= ready_d;
      val_q        <= val_d;
      pix_cnt_q    <= pix_cnt_d;
    end
  end

  // value bypasses the memory during RESP, then is held by val_q
  assign bus.pu_input_val   = (state_q == S_RESP) ?
                              bus.mem_rd_data : val_q;
  assign bus.pu_start       = {NUM_PU{state_q == S_START}};
  assign bus.pu_input_ready = ready_q;
  assign bus.mem_rd_en      = rd_en_q;
  assign bus.mem_rd_addr    = rd_addr_q;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.done           = (state_q == S_FINISH);
  assign bus.err            = err_q;

endmodule

// File: tb/tb_pu_input_scheduler.sv
// Bench for pu_input_scheduler with 4 PUs on a 2x2 feature map.
// Scoreboard of expected reads/responses, PU and memory models.
module tb_pu_input_scheduler;

  localparam int NP   = 4;
  localparam int BL   = 8;
  localparam int H    = 2;
  localparam int W    = 2;
  localparam int PIXW = 2;
  localparam int AW   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pu_input_scheduler_if #(
    .NUM_PU(NP), .BIN_LEN(BL), .ADDR_W(AW)
  ) bus ();

  pu_input_scheduler #(
    .NUM_PU(NP), .BIN_LEN(BL),
    .INPUT_HEIGHT(H), .INPUT_WIDTH(W)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_cyc = -10;
  int rdy_cyc = -1;
  bit spacing_on = 1'b0;
  int done_cnt = 0;
  int pstart_cnt = 0;
  logic [BL-1:0] mem [16];
  int exp_q[$];
  int resp_q[$];
  int want [NP];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc++;

  // activation memory: data valid one cycle after the strobe
  always @(posedge clk)
    bus.mem_rd_data <= bus.mem_rd_en ?
                       mem[bus.mem_rd_addr] : '0;

  // PUs: hold req while pixels are wanted, consume on ready
  always @(negedge clk) begin
    for (int k = 0; k < NP; k++) begin
      if (bus.pu_input_ready[k] === 1'b1 && want[k] > 0)
        want[k]--;
      bus.pu_input_req[k] = (want[k] != 0);
    end
  end

  // scoreboard: addr on each read, pu/value on each ready
  always @(negedge clk) begin
    int e;
    int r;
    if (rst_n) begin
      if (bus.mem_rd_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_read", 32'(bus.mem_rd_addr), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rd_addr", 32'(bus.mem_rd_addr), 32'(e));
          resp_q.push_back(((e >> PIXW) << 8) | int'(mem[e]));
        end
        rd_cyc = cyc;
      end
      if (bus.pu_input_ready !== '0) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_ready", 32'(bus.pu_input_ready), 0);
        end else begin
          r = resp_q.pop_front();
          chk("ready_onehot", 32'(bus.pu_input_ready),
              32'(1 << (r >> 8)));
          chk("ready_val", 32'(bus.pu_input_val),
              32'(r & 8'hFF));
          chk("ready_latency", 32'(cyc - rd_cyc), 1);
          if (spacing_on && rdy_cyc >= 0)
            chk("ready_spacing", 32'(cyc - rdy_cyc), 3);
        end
        rdy_cyc = cyc;
      end
      if (bus.done === 1'b1) done_cnt++;
      if (bus.pu_start === 4'hF) pstart_cnt++;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(int pu, int pix);
    exp_q.push_back(pu * (1 << PIXW) + pix);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic drain(string tag);
    int t = 0;
    while ((exp_q.size() != 0 || resp_q.size() != 0) && t < 200) begin
      tick();
      t++;
    end
    chk({tag, "_drain"}, 32'(t < 200), 1);
  endtask

  task automatic wait_rd(string tag);
    int t = 0;
    while (bus.mem_rd_en !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    chk({tag, "_wait_rd"}, 32'(t < 50), 1);
  endtask

  task automatic finish_layer(string tag);
    int d0 = done_cnt;
    int t = 0;
    bus.pu_done = '1;
    tick();
    bus.pu_done = '0;
    while (bus.busy !== 1'b0 && t < 50) begin
      tick();
      t++;
    end
    tick();
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 1);
    chk({tag, "_busy_low"}, 32'(bus.busy), 0);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_pu_start"}, 32'(bus.pu_start), 0);
    chk({tag, "_ready"}, 32'(bus.pu_input_ready), 0);
    chk({tag, "_val"}, 32'(bus.pu_input_val), 0);
    chk({tag, "_rd_en"}, 32'(bus.mem_rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(bus.mem_rd_addr), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
  endtask

  initial begin
    int d0;
    int p0;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    mem[8] = 8'h5A;
    for (int k = 0; k < NP; k++) want[k] = 0;
    bus.start = 1'b0;
    bus.pu_done = '0;

    rst_n = 1'b0;
    tick(3);
    chk_reset_outs("reset");
    rst_n = 1'b1;
    tick();

    // single requester
    want[2] = 2;
    push(2, 0);
    push(2, 1);
    pulse_start();
    chk("start_pulse", 32'(bus.pu_start), 4'hF);
    chk("start_busy", 32'(bus.busy), 1);
    drain("single");
    finish_layer("single");

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // contention, all four continuously
    for (int k = 0; k < NP; k++) want[k] = 2;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < NP; k++) push(k, p);
    spacing_on = 1'b1;
    rdy_cyc = -1;
    pulse_start();
    drain("contention");
    spacing_on = 1'b0;

    // fairness between PU0 and PU1
    want[0] = 2;
    want[1] = 2;
    push(0, 2);
    push(1, 2);
    push(0, 3);
    push(1, 3);
    drain("fair");
    chk("no_err_yet", 32'(bus.err), 0);

    // overrun: PU0 exhausted, others still served
    want[0] = 1;
    want[2] = 2;
    want[3] = 1;
    push(2, 2);
    push(3, 2);
    push(2, 3);
    drain("overrun");
    tick(3);
    chk("overrun_err", 32'(bus.err), 1);
    want[0] = 0;

    // completion with scattered done pulses
    bus.pu_done = 4'b0001;
    tick();
    bus.pu_done = '0;
    tick(2);
    want[3] = 1;
    push(3, 3);
    wait_rd("pu3");
    tick();
    bus.pu_done = 4'b1000;
    tick();
    bus.pu_done = '0;
    drain("pu3");
    bus.pu_done = 4'b0010;
    tick();
    bus.pu_done = '0;
    tick(3);
    chk("partial_busy", 32'(bus.busy), 1);
    chk("partial_no_done", 32'(bus.done), 0);
    p0 = pstart_cnt;
    pulse_start();
    tick(3);
    chk("start_ignored", 32'(pstart_cnt - p0), 0);
    d0 = done_cnt;
    bus.pu_done = 4'b0100;
    tick();
    bus.pu_done = '0;
    chk("mask_fill_no_done", 32'(bus.done), 0);
    tick();
    chk("finish_done", 32'(bus.done), 1);
    chk("finish_busy", 32'(bus.busy), 1);
    tick();
    chk("after_done", 32'(bus.done), 0);
    chk("after_busy", 32'(bus.busy), 0);
    chk("done_count", 32'(done_cnt - d0), 1);

    // reset during READ
    want[1] = 1;
    push(1, 0);
    pulse_start();
    wait_rd("midrst");
    chk("midrst_addr", 32'(bus.mem_rd_addr), 4);
    rst_n = 1'b0;
    tick();
    chk_reset_outs("midrst");
    rst_n = 1'b1;
    want[1] = 0;
    exp_q.delete();
    resp_q.delete();
    tick(2);

    // restart: PU0 has priority again
    want[0] = 1;
    want[3] = 1;
    push(0, 0);
    push(3, 0);
    pulse_start();
    drain("restart");
    finish_layer("restart");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
